// File: rtl/dtpu_job_launcher.sv
// dtpu_job_launcher: start/ready/done initiator that programs the precision CSR
// and runs N jobs on the control unit. Optional watchdog: DTPU_LAUNCH_WATCHDOG_EN.
module dtpu_job_launcher #(
    parameter int DATA_WIDTH_CSR   = 8,
    parameter int ADDRESS_SIZE_CSR = 32,
    parameter int CSR_PREC_ADDR    = 0,
    parameter int JOB_CNT_W        = 16,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [DATA_WIDTH_CSR-1:0]   cmd_cfg,
    input  logic [JOB_CNT_W-1:0]        cmd_jobs,
    input  logic                        abort,
    output logic                        csr_ce,
    output logic                        csr_we,
    output logic [ADDRESS_SIZE_CSR-1:0] csr_address,
    output logic [DATA_WIDTH_CSR-1:0]   csr_din,
    output logic                        cs_start,
    input  logic                        cs_ready,
    input  logic                        cs_done,
    input  logic                        cs_idle,
    output logic                        busy,
    output logic                        irq,
    output logic                        err_abort,
`ifdef DTPU_LAUNCH_WATCHDOG_EN
    output logic                        err_timeout,
`endif
    output logic [JOB_CNT_W-1:0]        jobs_done,
    output logic [2:0]                  state_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CFG_WR    = 3'd1,
        WAIT_IDLE = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        FINISH    = 3'd5,
        ERROR     = 3'd6
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t                        state_q, state_d;
    logic [DATA_WIDTH_CSR-1:0]     cfg_q, cfg_d;
    logic [JOB_CNT_W-1:0]          remaining_q, remaining_d;
    logic [JOB_CNT_W-1:0]          jobs_done_q, jobs_done_d;
    logic                          cmd_ready_q, cmd_ready_d;
    logic                          busy_q, busy_d;
    logic                          csr_ce_q, csr_ce_d;
    logic                          csr_we_q, csr_we_d;
    logic [ADDRESS_SIZE_CSR-1:0]   csr_address_q, csr_address_d;
    logic [DATA_WIDTH_CSR-1:0]     csr_din_q, csr_din_d;
    logic                          cs_start_q, cs_start_d;
    logic                          irq_q, irq_d;
    logic                          err_abort_q, err_abort_d;
    logic                          accept;
    logic                          abort_take;

`ifdef DTPU_LAUNCH_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_timeout_q, err_timeout_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cfg_q         <= '0;
            remaining_q   <= '0;
            jobs_done_q   <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            csr_ce_q      <= 1'b0;
            csr_we_q      <= 1'b0;
            csr_address_q <= '0;
            csr_din_q     <= '0;
            cs_start_q    <= 1'b0;
            irq_q         <= 1'b0;
            err_abort_q   <= 1'b0;
`ifdef DTPU_LAUNCH_WATCHDOG_EN
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            remaining_q   <= remaining_d;
            jobs_done_q   <= jobs_done_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            csr_ce_q      <= csr_ce_d;
            csr_we_q      <= csr_we_d;
            csr_address_q <= csr_address_d;
            csr_din_q     <= csr_din_d;
            cs_start_q    <= cs_start_d;
            irq_q         <= irq_d;
            err_abort_q   <= err_abort_d;
`ifdef DTPU_LAUNCH_WATCHDOG_EN
            wd_q          <= wd_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        remaining_d = remaining_q;
        jobs_done_d = jobs_done_q;
        accept      = 1'b0;
        abort_take  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    accept      = 1'b1;
                    cfg_d       = cmd_cfg;
                    remaining_d = cmd_jobs;
                    jobs_done_d = '0;
                    state_d     = (cmd_jobs == '0) ? FINISH : CFG_WR;
                end
            end
            CFG_WR:    state_d = WAIT_IDLE;
            WAIT_IDLE: if (cs_idle) state_d = START;
            START: begin
                if (cs_ready) begin
                    remaining_d = remaining_q - JOB_CNT_W'(1);
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cs_done) begin
                    if (jobs_done_q != '1)
                        jobs_done_d = jobs_done_q + JOB_CNT_W'(1);
                    state_d = (remaining_q == '0) ? FINISH : WAIT_IDLE;
                end
            end
            FINISH:  state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef DTPU_LAUNCH_WATCHDOG_EN
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (state_q == START || state_q == WAIT_DONE) begin
            wd_d = wd_q + WD_W'(1);
            if (wd_d == WD_W'(TIMEOUT_CYCLES))
                state_d = ERROR;
        end
`endif
        // Abort wins over any ready/done sampled in the same cycle.
        if (abort && state_q != IDLE) begin
            abort_take  = 1'b1;
            state_d     = IDLE;
            remaining_d = remaining_q;
            jobs_done_d = jobs_done_q;
        end
    end

    always_comb begin
        cmd_ready_d   = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        csr_ce_d      = (state_d == CFG_WR);
        csr_we_d      = (state_d == CFG_WR);
        csr_address_d = csr_ce_d ? ADDRESS_SIZE_CSR'(CSR_PREC_ADDR) : '0;
        csr_din_d     = csr_ce_d ? cfg_d : '0;
        cs_start_d    = (state_d == START);
        irq_d         = abort_take || (state_q == FINISH) ||
                        (state_d == ERROR);
        err_abort_d   = accept ? 1'b0 : (err_abort_q || abort_take);
`ifdef DTPU_LAUNCH_WATCHDOG_EN
        err_timeout_d = accept ? 1'b0 :
                        (err_timeout_q || (state_d == ERROR));
`endif
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign csr_ce      = csr_ce_q;
    assign csr_we      = csr_we_q;
    assign csr_address = csr_address_q;
    assign csr_din     = csr_din_q;
    assign cs_start    = cs_start_q;
    assign irq         = irq_q;
    assign err_abort   = err_abort_q;
    assign jobs_done   = jobs_done_q;
    assign state_out   = state_q;
`ifdef DTPU_LAUNCH_WATCHDOG_EN
    assign err_timeout = err_timeout_q;
`endif

endmodule

// File: doc/dtpu_job_launcher.md
Name: dtpu_job_launcher

Overview:
- Initiator side of the DTPU start/ready/done control handshake; the control unit is the responder.
- Accepts a job command from the PS-side register slice and writes the arithmetic-precision CSR word.
- Then launches N back-to-back MXU jobs by driving cs_start, tracking cs_ready/cs_done, and raising a completion interrupt.
- Sits between the AXI-lite register bank and the control unit / CSR memory write port.

Parameters:
DATA_WIDTH_CSR, 8, CSR data width (matches the CSR memory)
ADDRESS_SIZE_CSR, 32, CSR address width
CSR_PREC_ADDR, 0, CSR address of the arithmetic-precision/chain/fp-mode word
JOB_CNT_W, 16, width of job count and completed-job counter
TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  new job command present
cmd_ready  out  1  launcher can accept a command (high only in IDLE)
cmd_cfg  in  DATA_WIDTH_CSR  precision/chain/fp word to write into the CSR
cmd_jobs  in  JOB_CNT_W  number of jobs to run
abort  in  1  cancel the current sequence
csr_ce  out  1  CSR chip enable
csr_we  out  1  CSR write enable
csr_address  out  ADDRESS_SIZE_CSR  CSR address
csr_din  out  DATA_WIDTH_CSR  CSR write data
cs_start  out  1  start request to the control unit
cs_ready  in  1  control unit accepted start (1-cycle pulse)
cs_done  in  1  control unit finished a job (1-cycle pulse)
cs_idle  in  1  control unit is in idle
busy  out  1  sequence in progress
irq  out  1  1-cycle completion/error pulse
err_abort  out  1  sticky: last sequence aborted
jobs_done  out  JOB_CNT_W  jobs completed in the current/last sequence
state_out  out  3  debug state encoding

Behaviour:
- All outputs are registered. On reset=0 at a clk edge: every output is 0, state=IDLE, counters are 0, and err flags are cleared.
- States and encodings: IDLE=0, CFG_WR=1, WAIT_IDLE=2, START=3, WAIT_DONE=4, FINISH=5, ERROR=6.
- IDLE:
  - cmd_ready=1 and busy=0.
  - On cmd_valid&&cmd_ready: latch cmd_cfg and cmd_jobs, clear jobs_done and the err flags, then set cmd_ready=0 and busy=1 on the next cycle.
  - If cmd_jobs==0, go to FINISH. Otherwise go to CFG_WR.
- CFG_WR:
  - For exactly 1 cycle drive csr_ce=1, csr_we=1, csr_address=CSR_PREC_ADDR, csr_din=latched cfg.
  - Then go to WAIT_IDLE. Outside this state csr_ce=csr_we=0 and address/data=0.
- WAIT_IDLE: hold until cs_idle==1 is sampled, then go to START.
- START:
  - cs_start=1, held continuously; the responder needs start high for at least 3 consecutive cycles.
  - When cs_ready==1 is sampled, drop cs_start to 0 on the next edge, decrement remaining, and go to WAIT_DONE.
- WAIT_DONE:
  - cs_start=0. When cs_done==1 is sampled, increment jobs_done.
  - If remaining==0 go to FINISH, else go to WAIT_IDLE.
  - A cs_done pulse arriving in any other state is ignored.
- FINISH: irq=1 for 1 cycle, busy=0 next cycle, go to IDLE.
- abort:
  - abort=1 sampled in any state except IDLE: next cycle cs_start=0, err_abort=1, irq pulse, go to IDLE.
  - Abort has priority over cs_ready/cs_done sampled in the same cycle; that ready or done is not counted.
- cs_ready and cs_done both high in the same cycle in START: take the ready, go to WAIT_DONE, and count the done on the next sample only. The responder never does this; the rule is defined for robustness.
- jobs_done saturates at 2^JOB_CNT_W-1 and never wraps.
- cmd_valid outside IDLE is ignored; the command is neither accepted nor queued.

Optional Feature:
- Macro: DTPU_LAUNCH_WATCHDOG_EN.
- When defined:
  - A cycle counter clears on entry to START and to WAIT_DONE and increments every cycle in those states.
  - On reaching TIMEOUT_CYCLES, go to ERROR.
  - In ERROR, an extra output err_timeout (1 bit, sticky until the next accepted command) goes high, cs_start=0, irq pulses 1 cycle, and the block returns to IDLE.
- When undefined: no counter, no err_timeout port, and START/WAIT_DONE wait indefinitely.

Test Plan:
- Single job: cmd_cfg=8'h05, cmd_jobs=1, responder model pulses ready 3 cycles after start and done 20 cycles later -> one CSR write of 8'h05 at CSR_PREC_ADDR, cs_start high exactly until the ready, jobs_done=1, one irq pulse, cmd_ready back to 1.
- Multi job: cmd_jobs=4, cs_idle dropped for 5 cycles between jobs -> cs_start waits for cs_idle each time, 4 start/ready pairs, jobs_done=4, irq only once at the end.
- Zero jobs: cmd_jobs=0 -> no CSR write, no cs_start, irq 2 cycles after acceptance, jobs_done=0.
- Abort while in WAIT_DONE after 2 of 3 jobs, with cs_done pulsed in the same cycle -> jobs_done=2, err_abort=1, irq pulse, IDLE; err_abort clears on the next accepted command.
- Reset asserted mid-START -> next cycle cs_start=0, busy=0, jobs_done=0, cmd_ready=0; cmd_ready=1 one cycle after reset releases.
- DTPU_LAUNCH_WATCHDOG_EN with TIMEOUT_CYCLES=16 and a responder that never asserts ready -> err_timeout=1 and irq 16 cycles after entering START, cs_start=0 afterwards.
